// File: rtl/uart_core_fifo.sv
// UART core: tick generator, framed transmitter, oversampling receiver and
// TX/RX FIFOs behind a push/pop bus handshake with sticky status flags.

module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == FULL_COUNT);
   assign empty     = (count_r == '0);
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign head      = mem_r[rd_ptr_r];

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module uart_core_fifo #(
   parameter int DATA_SIZE  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int SYS_FREQ   = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int SAMPLE     = 16,
   parameter int BAUD_DVSR  = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write_data,
   input  logic [DATA_SIZE-1:0] bus_data_in,
   input  logic                 read_data,
   output logic [DATA_SIZE-1:0] bus_data_out,
   input  logic                 serial_data_in,
   output logic                 serial_data_out,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   input  logic                 clear_errors,
   output logic [7:0]           TX_status_register,
   output logic [7:0]           RX_status_register
);
   localparam int DVW = $clog2(BAUD_DVSR);
   localparam int SW  = $clog2(SAMPLE);
   localparam int BW  = $clog2(DATA_SIZE);
   localparam logic [DVW-1:0] TICK_LAST   = DVW'(BAUD_DVSR - 1);
   localparam logic [SW-1:0]  SAMPLE_LAST = SW'(SAMPLE - 1);
   localparam logic [SW-1:0]  HALF_LAST   = SW'(SAMPLE / 2 - 1);
   localparam logic [BW-1:0]  BIT_LAST    = BW'(DATA_SIZE - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   function automatic logic calc_parity(input logic [DATA_SIZE-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   logic [DVW-1:0]       tick_cnt_r;
   logic                 tick_s;
   logic [DATA_SIZE-1:0] tx_head_s, rx_head_s;
   logic                 tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic                 tx_pop_s, rx_push_s, rx_pop_s;
   logic [2:0]           tx_state_r, rx_state_r;
   logic                 tx_pend_r, tx_par_en_r, tx_two_stop_r, tx_par_bit_r, tx_stop2_r;
   logic [SW-1:0]        tx_tcnt_r, rx_tcnt_r;
   logic [BW-1:0]        tx_bit_r, rx_bit_r;
   logic [DATA_SIZE-1:0] tx_shift_r, rx_shift_r;
   logic                 tx_bit_end_s, serial_out_r;
   logic                 rx_par_en_r, rx_par_odd_r, rx_par_r;
   logic                 rx_half_s, rx_sample_s, rx_stop_s, rx_break_s;
   logic                 tx_ovf_r, rx_par_err_r, rx_stop_err_r, rx_brk_r, rx_ovf_r, rx_unf_r;

   assign tick_s = (tick_cnt_r == TICK_LAST);

   // free-running oversample tick divider
   always_ff @(posedge clk) begin
      if (reset || tick_s) tick_cnt_r <= '0;
      else                 tick_cnt_r <= tick_cnt_r + DVW'(1);
   end

   assign tx_pop_s = (tx_state_r == ST_IDLE) && !tx_pend_r && !tx_empty_s;
   assign rx_pop_s = read_data && !rx_empty_s;

   uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(write_data), .pop(tx_pop_s),
      .din(bus_data_in), .head(tx_head_s), .empty(tx_empty_s), .full(tx_full_s));

   uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push_s), .pop(rx_pop_s),
      .din(rx_shift_r), .head(rx_head_s), .empty(rx_empty_s), .full(rx_full_s));

   assign tx_bit_end_s = tick_s && (tx_tcnt_r == SAMPLE_LAST);

   // transmitter: the popped word waits in IDLE (pending) until the next tick starts the frame
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_r <= ST_IDLE;   tx_pend_r    <= 1'b0;  tx_tcnt_r     <= '0;
         tx_bit_r   <= '0;        tx_shift_r   <= '0;    tx_par_en_r   <= 1'b0;
         tx_stop2_r <= 1'b0;      tx_par_bit_r <= 1'b0;  tx_two_stop_r <= 1'b0;
         serial_out_r <= 1'b1;
      end else begin
         if (tx_state_r == ST_IDLE || tx_bit_end_s) tx_tcnt_r <= '0;
         else if (tick_s)                           tx_tcnt_r <= tx_tcnt_r + SW'(1);
         case (tx_state_r)
            ST_IDLE: begin
               if (tx_pop_s) begin
                  tx_shift_r    <= tx_head_s;
                  tx_par_en_r   <= parity_en;
                  tx_two_stop_r <= two_stop;
                  tx_par_bit_r  <= calc_parity(tx_head_s, parity_odd);
                  tx_pend_r     <= 1'b1;
               end else if (tx_pend_r && tick_s) begin
                  tx_state_r   <= ST_START;
                  tx_pend_r    <= 1'b0;
                  serial_out_r <= 1'b0;
               end
            end
            ST_START: if (tx_bit_end_s) begin
               tx_state_r   <= ST_DATA;
               tx_bit_r     <= '0;
               serial_out_r <= tx_shift_r[0];
            end
            ST_DATA: if (tx_bit_end_s) begin
               if (tx_bit_r == BIT_LAST) begin
                  tx_stop2_r   <= 1'b0;
                  tx_state_r   <= tx_par_en_r ? ST_PARITY : ST_STOP;
                  serial_out_r <= tx_par_en_r ? tx_par_bit_r : 1'b1;
               end else begin
                  tx_bit_r     <= tx_bit_r + BW'(1);
                  tx_shift_r   <= tx_shift_r >> 1;
                  serial_out_r <= tx_shift_r[1];
               end
            end
            ST_PARITY: if (tx_bit_end_s) begin
               tx_state_r   <= ST_STOP;
               serial_out_r <= 1'b1;
            end
            ST_STOP: if (tx_bit_end_s) begin
               if (tx_two_stop_r && !tx_stop2_r) tx_stop2_r <= 1'b1;
               else                              tx_state_r <= ST_IDLE;
            end
            default: begin
               tx_state_r   <= ST_IDLE;
               serial_out_r <= 1'b1;
            end
         endcase
      end
   end

   assign serial_data_out = serial_out_r;

   assign rx_half_s   = tick_s && (rx_state_r == ST_START) && (rx_tcnt_r == HALF_LAST);
   assign rx_sample_s = tick_s && (rx_tcnt_r == SAMPLE_LAST);
   assign rx_stop_s   = (rx_state_r == ST_STOP) && rx_sample_s;
   assign rx_break_s  = rx_stop_s && !serial_data_in && (rx_shift_r == '0) && !(rx_par_en_r && rx_par_r);
   assign rx_push_s   = rx_stop_s && !rx_break_s;

   // receiver: mid-bit sampling anchored on the half-bit start re-check
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_r  <= ST_IDLE; rx_tcnt_r    <= '0;   rx_bit_r <= '0;
         rx_shift_r  <= '0;      rx_par_en_r  <= 1'b0; rx_par_odd_r <= 1'b0;
         rx_par_r    <= 1'b0;
      end else begin
         if (rx_state_r == ST_IDLE || rx_state_r == ST_BREAK || rx_half_s || rx_sample_s)
            rx_tcnt_r <= '0;
         else if (tick_s)
            rx_tcnt_r <= rx_tcnt_r + SW'(1);
         case (rx_state_r)
            ST_IDLE: if (tick_s && !serial_data_in) begin
               rx_state_r   <= ST_START;
               rx_par_en_r  <= parity_en;
               rx_par_odd_r <= parity_odd;
               rx_par_r     <= 1'b0;
            end
            ST_START: if (rx_half_s) begin
               rx_state_r <= serial_data_in ? ST_IDLE : ST_DATA;
               rx_bit_r   <= '0;
            end
            ST_DATA: if (rx_sample_s) begin
               rx_shift_r <= {serial_data_in, rx_shift_r[DATA_SIZE-1:1]};
               if (rx_bit_r == BIT_LAST) rx_state_r <= rx_par_en_r ? ST_PARITY : ST_STOP;
               else                      rx_bit_r   <= rx_bit_r + BW'(1);
            end
            ST_PARITY: if (rx_sample_s) begin
               rx_par_r   <= serial_data_in;
               rx_state_r <= ST_STOP;
            end
            ST_STOP:  if (rx_sample_s) rx_state_r <= rx_break_s ? ST_BREAK : ST_IDLE;
            ST_BREAK: if (tick_s && serial_data_in) rx_state_r <= ST_IDLE;
            default:  rx_state_r <= ST_IDLE;
         endcase
      end
   end

   // sticky flags: a same-cycle error event takes priority over clear_errors
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ovf_r <= 1'b0; rx_par_err_r <= 1'b0; rx_stop_err_r <= 1'b0;
         rx_brk_r <= 1'b0; rx_ovf_r     <= 1'b0; rx_unf_r      <= 1'b0;
      end else begin
         tx_ovf_r      <= (write_data && tx_full_s) || (tx_ovf_r && !clear_errors);
         rx_par_err_r  <= (rx_push_s && rx_par_en_r && (rx_par_r != calc_parity(rx_shift_r, rx_par_odd_r)))
                          || (rx_par_err_r && !clear_errors);
         rx_stop_err_r <= (rx_push_s && !serial_data_in) || (rx_stop_err_r && !clear_errors);
         rx_brk_r      <= rx_break_s || (rx_brk_r && !clear_errors);
         rx_ovf_r      <= (rx_push_s && rx_full_s) || (rx_ovf_r && !clear_errors);
         rx_unf_r      <= (read_data && rx_empty_s) || (rx_unf_r && !clear_errors);
      end
   end

   // read port: holds the last successfully popped word
   always_ff @(posedge clk) begin
      if (reset)         bus_data_out <= '0;
      else if (rx_pop_s) bus_data_out <= rx_head_s;
   end

   assign TX_status_register = {4'b0000, tx_ovf_r, (tx_state_r != ST_IDLE), tx_full_s, tx_empty_s};
   assign RX_status_register = {(rx_state_r != ST_IDLE), rx_unf_r, rx_ovf_r, rx_brk_r,
                                rx_stop_err_r, rx_par_err_r, rx_full_s, !rx_empty_s};
endmodule

// File: doc/uart_core_fifo.md
Name: uart_core_fifo

Overview:
- Next-generation UART core: baud/oversample tick generator, transmitter and oversampling receiver, with parametrised TX and RX FIFOs.
- Frame format is selectable at run time: data width from parameter, parity none/even/odd, 1 or 2 stop bits.
- Exposes a simple bus write/read handshake and two 8-bit status registers with sticky error flags.
- Sits between the bus-side register block and the serial pins.

Parameters:
- DATA_SIZE, 8, data bits per frame, legal range 5..9.
- FIFO_DEPTH, 8, entries per FIFO, power of 2, at least 2.
- SYS_FREQ, 100000000, clk frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- SAMPLE, 16, oversample ticks per bit, even.
- BAUD_DVSR, SYS_FREQ/(SAMPLE*BAUD_RATE), clk cycles per tick, at least 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-high.
- write_data  in  1  push bus_data_in into the TX FIFO.
- bus_data_in  in  DATA_SIZE  TX data.
- read_data  in  1  pop the RX FIFO.
- bus_data_out  out  DATA_SIZE  last word popped from RX.
- serial_data_in  in  1  RX line, idle high, already synchronised externally.
- serial_data_out  out  1  TX line, idle high.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- two_stop  in  1  1 = 2 stop bits, 0 = 1 stop bit.
- clear_errors  in  1  1-cycle pulse that clears the sticky flags.
- TX_status_register  out  8  [0] empty, [1] full, [2] busy, [3] overflow (sticky), [7:4] 0.
- RX_status_register  out  8  [0] not empty, [1] full, [2] parity error, [3] stop error, [4] break error, [5] overflow, [6] underflow, [7] busy. Bits [6:2] are sticky.

Behaviour:
- Reset, sampled synchronously:
  - FIFO pointers and counts = 0; both FSMs IDLE; tick counter = 0.
  - serial_data_out = 1; bus_data_out = 0.
  - TX_status_register = 8'h01; RX_status_register = 8'h00.
- Reset mid-frame aborts the frame; serial_data_out is 1 on the cycle after reset is sampled.
- Tick generator:
  - Counter runs 0..BAUD_DVSR-1.
  - tick is high for 1 cycle when the counter = BAUD_DVSR-1.
  - Bit time = SAMPLE ticks.
- Bus write:
  - write_data with TX not full: entry pushed.
  - write_data with TX full: word dropped, overflow [3] set. A same-cycle TX pop does not prevent the drop.
- Bus read:
  - read_data with RX not empty: head loaded into bus_data_out on the next edge (1-cycle latency); bus_data_out holds until the next successful read.
  - read_data with RX empty: underflow [6] set, bus_data_out unchanged.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged. Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: when FIFO is non-empty, pop the head into the shift register and latch parity_en/parity_odd/two_stop. These stay fixed for the whole frame.
  - Go to START aligned to the next tick.
  - Each bit lasts SAMPLE ticks. START drives 0. DATA drives DATA_SIZE bits LSB first.
  - PARITY state only when parity_en. Bit = XOR of data, inverted when parity_odd.
  - STOP drives 1 for 1 or 2 bit times, then IDLE. A back-to-back frame may start on the next tick.
  - busy [2] = state != IDLE.
- RX FSM, states IDLE, START, DATA, PARITY, STOP, BREAK:
  - IDLE: on tick with line 0, go to START.
  - START: after SAMPLE/2 ticks, re-sample. Line 1 = false start, back to IDLE with no flags. Line 0 = go to DATA.
  - DATA, PARITY and STOP: sample every SAMPLE ticks (mid-bit). Config is latched at the start-bit detect.
  - Only the first stop bit is checked; the receiver does not wait for a second stop bit.
- RX outcome at the stop sample:
  - Break: data all 0, parity bit 0 if present, stop 0. Set break error [4], push nothing, go to BREAK. Leave BREAK on the first tick with line 1.
  - Otherwise push the data. Parity mismatch sets [2]. Stop = 0 sets [3]; data is still pushed in both cases.
  - Push when RX full: word dropped, overflow [5] set.
- RX busy [7] = state != IDLE.
- clear_errors clears all sticky bits on the next edge. If an error event occurs in the same cycle, the event wins and the bit stays set.

Test Plan:
Bench parameters SYS_FREQ=1600000, BAUD_RATE=10000, SAMPLE=16 (BAUD_DVSR=10, 160 clk/bit), DATA_SIZE=8, FIFO_DEPTH=8.
1. Loopback, 8N1, write 8'hA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each held 160 clk; RX status[0]=1; read_data gives bus_data_out=8'hA5 one cycle later; status[6:2]=0.
2. parity_en=1, parity_odd=0; drive 8'h03 with parity bit 1 -> word 8'h03 stored, RX[2]=1; clear_errors -> RX[2]=0.
3. 10 back-to-back writes 8'h00..8'h09 while idle -> TX[3]=1, TX[1]=1; exactly 8'h00..8'h08 transmitted, in order.
4. serial_data_in held low for 12 bit times -> RX[4]=1, RX FIFO stays empty, RX returns to IDLE after the line goes high.
5. Low pulse of 60 clk -> no push, no flags, RX[7] back to 0. Send 9 frames with no reads -> 8 stored, RX[5]=1. Read on empty -> RX[6]=1.
6. Assert reset in the middle of the DATA bits of a TX frame -> serial_data_out=1 the next cycle, TX_status=8'h01, a new write transmits normally.
